// File: rtl/mips_data_mem_if.sv
// mips_data_mem_if
//   Request/response bundle between the MIPS core memory port (master) and
//   the data-memory responder (slave).
//   req_valid    master->slave  request present
//   req_write    master->slave  1 = store, 0 = load
//   req_addr     master->slave  byte address (XLEN bits)
//   req_wdata    master->slave  store data, lane i -> byte addr+i
//   req_ready    slave->master  responder can accept a request this cycle
//   resp_valid   slave->master  one-cycle response strobe
//   resp_rdata   slave->master  load data, lane i = byte addr+i
//   misalign_err slave->master  misaligned-request flag, qualified by resp_valid
interface mips_data_mem_if #(
  parameter int XLEN = 32
);
  logic             req_valid;
  logic             req_write;
  logic [XLEN-1:0]  req_addr;
  logic [3:0][7:0]  req_wdata;
  logic             req_ready;
  logic             resp_valid;
  logic [3:0][7:0]  resp_rdata;
  logic             misalign_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, misalign_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, misalign_err
  );
endinterface

// File: rtl/mips_data_mem.sv
// mips_data_mem
//   Multi-cycle word load/store responder with a byte-organised store of
//   2^ADDR_BITS bytes. One request at a time over valid/ready; the access is
//   committed LATENCY-1 edges after acceptance and answered by a one-cycle
//   resp_valid strobe. Byte addresses wrap modulo 2^ADDR_BITS; upper address
//   bits are ignored (aliased).
// Ports
//   clk    clock, rising edge
//   rst_b  synchronous reset, active-high (name inherited from the codebase)
//   bus    mips_data_mem_if.slave (request/response signals)
// Optional feature
//   MEM_MISALIGN_CHECK_EN: when defined, requests with addr[1:0] != 0 write
//   nothing, return zero data and raise misalign_err with resp_valid. When
//   undefined, misaligned words are legal and misalign_err is always 0.
module mips_data_mem #(
  parameter int XLEN      = 32,
  parameter int ADDR_BITS = 12,
  parameter int LATENCY   = 4
) (
  input  logic           clk,
  input  logic           rst_b,
  mips_data_mem_if.slave bus
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  localparam int DEPTH = 1 << ADDR_BITS;

  logic [7:0]           mem_q [DEPTH];

  state_e               state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic                 ready_q;
  logic                 resp_valid_q;
  logic                 misalign_q;
  logic [3:0][7:0]      rdata_q;

  logic [ADDR_BITS-1:0] addr_q;
  logic                 write_q;
  logic [3:0][7:0]      wdata_q;

  logic                 accept;
  logic                 commit;
  logic [ADDR_BITS-1:0] acc_addr;
  logic                 acc_write;
  logic [3:0][7:0]      acc_wdata;
  logic                 acc_mis;
  logic [3:0][7:0]      rd_word;

  logic                 unused_addr_hi;
  assign unused_addr_hi = ^bus.req_addr[XLEN-1:ADDR_BITS];

  assign accept = ready_q & bus.req_valid;

  // With LATENCY=1 the access happens on the acceptance edge itself, so the
  // live request is used; otherwise the captured request is used in WAIT.
  assign commit = (accept && (LATENCY == 1)) ||
                  ((state_q == WAIT) && (cnt_q == 4'd1));

  always_comb begin
    if (state_q == WAIT) begin
      acc_addr  = addr_q;
      acc_write = write_q;
      acc_wdata = wdata_q;
    end else begin
      acc_addr  = bus.req_addr[ADDR_BITS-1:0];
      acc_write = bus.req_write;
      acc_wdata = bus.req_wdata;
    end
  end

`ifdef MEM_MISALIGN_CHECK_EN
  assign acc_mis = |acc_addr[1:0];
`else
  assign acc_mis = 1'b0;
`endif

  // Byte lanes wrap naturally through the ADDR_BITS-wide addition.
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < 4; i++) begin
      rd_word[i] = mem_q[acc_addr + ADDR_BITS'(i)];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE, RESP: begin
        if (accept) begin
          if (LATENCY == 1) begin
            state_d = RESP;
            cnt_d   = 4'd0;
          end else begin
            state_d = WAIT;
            cnt_d   = 4'(LATENCY - 1);
          end
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = RESP;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_b) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      ready_q      <= 1'b1;
      resp_valid_q <= 1'b0;
      misalign_q   <= 1'b0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ready_q      <= (state_d != WAIT);
      resp_valid_q <= commit;
      misalign_q   <= commit & acc_mis;
      // Read data holds between responses; stores and rejected requests
      // answer with zero.
      if (commit) rdata_q <= (acc_write || acc_mis) ? '0 : rd_word;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q  <= bus.req_addr[ADDR_BITS-1:0];
      write_q <= bus.req_write;
      wdata_q <= bus.req_wdata;
    end
  end

  // Reset on the commit edge wins: the store is dropped.
  always_ff @(posedge clk) begin
    if (!rst_b && commit && acc_write && !acc_mis) begin
      for (int i = 0; i < 4; i++) begin
        mem_q[acc_addr + ADDR_BITS'(i)] <= acc_wdata[i];
      end
    end
  end

  assign bus.req_ready    = ready_q;
  assign bus.resp_valid   = resp_valid_q;
  assign bus.resp_rdata   = rdata_q;
  assign bus.misalign_err = misalign_q;

endmodule

// File: tb/tb_mips_data_mem.sv
module tb_mips_data_mem;

  localparam int LATENCY   = 4;
  localparam int ADDR_BITS = 12;
  localparam int DEPTH     = 1 << ADDR_BITS;

`ifdef MEM_MISALIGN_CHECK_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  logic clk;
  logic rst_b;

  mips_data_mem_if #(.XLEN(32)) bus ();

  mips_data_mem #(
    .XLEN      (32),
    .ADDR_BITS (ADDR_BITS),
    .LATENCY   (LATENCY)
  ) dut (
    .clk   (clk),
    .rst_b (rst_b),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference byte store, updated from committed transactions only.
  logic [7:0] mem_m [DEPTH];

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] er;
    logic        em;
  } vec_t;

  vec_t tbl [13];

  function automatic logic [31:0] lanes(input logic [7:0] b0, input logic [7:0] b1,
                                        input logic [7:0] b2, input logic [7:0] b3);
    return {b3, b2, b1, b0};
  endfunction

  function automatic bit is_mis(input logic [31:0] a);
    return MIS_EN && (a % 4 != 0);
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] a);
    logic [31:0] r;
    r = 32'h0;
    if (!is_mis(a)) begin
      for (int i = 0; i < 4; i++) r[8*i +: 8] = mem_m[(a + i) % DEPTH];
    end
    return r;
  endfunction

  task automatic model_apply(input logic w, input logic [31:0] a, input logic [31:0] wd);
    if (w && !is_mis(a)) begin
      for (int i = 0; i < 4; i++) mem_m[(a + i) % DEPTH] = wd[8*i +: 8];
    end
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge where resp_valid is seen.
  task automatic do_txn(input logic w, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] er, input logic em, input string nm);
    int lat;
    int guard;
    guard = 0;
    while (!bus.req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    bus.req_valid = 1'b1;
    bus.req_write = w;
    bus.req_addr  = a;
    bus.req_wdata = wd;
    @(negedge clk);
    bus.req_valid = 1'b0;
    lat = 1;
    while (!bus.resp_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check({nm, "_lat"}, 32'(lat), 32'(LATENCY));
    check({nm, "_rdata"}, bus.resp_rdata, er);
    check({nm, "_mis"}, 32'(bus.misalign_err), 32'(em));
  endtask

  initial begin
    int t;
    int seen;
    logic        rw;
    logic [31:0] ra;
    logic [31:0] rd;

    rst_b         = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = 32'h0;
    bus.req_wdata = '0;
    for (int i = 0; i < DEPTH; i++) mem_m[i] = 8'h0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_b = 1'b0;

    // Reset state and three idle cycles.
    for (int i = 0; i < 3; i++) begin
      check("idle_ready", 32'(bus.req_ready), 32'h1);
      check("idle_valid", 32'(bus.resp_valid), 32'h0);
      check("idle_rdata", bus.resp_rdata, 32'h0);
      check("idle_mis", 32'(bus.misalign_err), 32'h0);
      @(negedge clk);
    end

    // Zero-fill storage through the port (contents are not reset).
    for (int a = 0; a < DEPTH; a += 4) do_txn(1'b1, 32'(a), 32'h0, 32'h0, 1'b0, "fill");

    tbl[0]  = '{1'b1, 32'h0000_0010, lanes(8'hDE, 8'hAD, 8'hBE, 8'hEF), 32'h0, 1'b0};
    tbl[1]  = '{1'b0, 32'h0000_0010, 32'h0, lanes(8'hDE, 8'hAD, 8'hBE, 8'hEF), 1'b0};
    tbl[2]  = '{1'b1, 32'h0000_0014, lanes(8'h01, 8'h02, 8'h03, 8'h04), 32'h0, 1'b0};
    tbl[3]  = '{1'b0, 32'h0000_0014, 32'h0, lanes(8'h01, 8'h02, 8'h03, 8'h04), 1'b0};
    tbl[4]  = '{1'b1, 32'h0000_0FFE, lanes(8'h11, 8'h22, 8'h33, 8'h44), 32'h0, MIS_EN};
    tbl[5]  = '{1'b0, 32'h0000_0000, 32'h0,
                MIS_EN ? 32'h0 : lanes(8'h33, 8'h44, 8'h00, 8'h00), 1'b0};
    tbl[6]  = '{1'b0, 32'h0000_1000, 32'h0,
                MIS_EN ? 32'h0 : lanes(8'h33, 8'h44, 8'h00, 8'h00), 1'b0};
    tbl[7]  = '{1'b0, 32'h0000_0FFC, 32'h0,
                MIS_EN ? 32'h0 : lanes(8'h00, 8'h00, 8'h11, 8'h22), 1'b0};
    tbl[8]  = '{1'b1, 32'h0000_0021, lanes(8'h55, 8'h55, 8'h55, 8'h55), 32'h0, MIS_EN};
    tbl[9]  = '{1'b0, 32'h0000_0020, 32'h0,
                MIS_EN ? 32'h0 : lanes(8'h00, 8'h55, 8'h55, 8'h55), 1'b0};
    tbl[10] = '{1'b0, 32'h0000_0024, 32'h0,
                MIS_EN ? 32'h0 : lanes(8'h55, 8'h00, 8'h00, 8'h00), 1'b0};
    tbl[11] = '{1'b0, 32'h0000_1010, 32'h0, lanes(8'hDE, 8'hAD, 8'hBE, 8'hEF), 1'b0};
    tbl[12] = '{1'b0, 32'h0000_0FFE, 32'h0,
                MIS_EN ? 32'h0 : lanes(8'h11, 8'h22, 8'h33, 8'h44), MIS_EN};

    for (int i = 0; i < 13; i++) begin
      do_txn(tbl[i].w, tbl[i].a, tbl[i].wd, tbl[i].er, tbl[i].em, $sformatf("tbl%0d", i));
      model_apply(tbl[i].w, tbl[i].a, tbl[i].wd);
    end

    // Back-to-back loads with req_valid held: second accepted during RESP.
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_addr  = 32'h10;
    @(negedge clk);
    bus.req_addr  = 32'h14;
    t = 1;
    while (!bus.resp_valid && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("b2b_first_lat", 32'(t), 32'(LATENCY));
    check("b2b_first_rdata", bus.resp_rdata, lanes(8'hDE, 8'hAD, 8'hBE, 8'hEF));
    check("b2b_resp_ready", 32'(bus.req_ready), 32'h1);
    @(negedge clk);
    bus.req_valid = 1'b0;
    t = 1;
    while (!bus.resp_valid && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("b2b_gap", 32'(t), 32'(LATENCY));
    check("b2b_second_rdata", bus.resp_rdata, lanes(8'h01, 8'h02, 8'h03, 8'h04));
    @(negedge clk);
    check("b2b_one_cycle", 32'(bus.resp_valid), 32'h0);
    check("b2b_rdata_hold", bus.resp_rdata, lanes(8'h01, 8'h02, 8'h03, 8'h04));

    // Reset two cycles after accepting a store: aborted.
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_addr  = 32'h40;
    bus.req_wdata = lanes(8'hAA, 8'hAA, 8'hAA, 8'hAA);
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    rst_b = 1'b1;
    @(negedge clk);
    rst_b = 1'b0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (bus.resp_valid) seen++;
      @(negedge clk);
    end
    check("abort_no_resp", 32'(seen), 32'h0);
    check("abort_ready", 32'(bus.req_ready), 32'h1);
    check("abort_rdata_reset", bus.resp_rdata, 32'h0);
    do_txn(1'b0, 32'h40, 32'h0, 32'h0, 1'b0, "abort_load");

    // Reset sampled on the commit edge: no write.
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_addr  = 32'h44;
    bus.req_wdata = lanes(8'hBB, 8'hBB, 8'hBB, 8'hBB);
    @(negedge clk);
    bus.req_valid = 1'b0;
    repeat (LATENCY - 2) @(negedge clk);
    rst_b = 1'b1;
    @(negedge clk);
    rst_b = 1'b0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (bus.resp_valid) seen++;
      @(negedge clk);
    end
    check("commit_rst_no_resp", 32'(seen), 32'h0);
    do_txn(1'b0, 32'h44, 32'h0, 32'h0, 1'b0, "commit_rst_load");

    // Randomised traffic against the reference store.
    for (int n = 0; n < 300; n++) begin
      rw = 1'($urandom_range(0, 1));
      ra = $urandom;
      if (n % 3 == 0) ra = {ra[31:6], 6'h0} | 32'($urandom_range(0, 15));
      rd = $urandom;
      do_txn(rw, ra, rd, rw ? 32'h0 : model_load(ra), is_mis(ra), "rand");
      model_apply(rw, ra, rd);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
